// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution bank sequencer.
// Imported by the sequencer top and its window address generator.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic int beats_per_window(input int k);
    return (k * k + 1) / 2;
  endfunction

  function automatic int num_windows(
    input int w,
    input int h,
    input int k
  );
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window origin and kernel-beat cursors for a dual-read bank scan.
// Produces two element addresses per beat plus first/last/final flags.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  output logic [ADDR_SIZE-1:0] addr_1,
  output logic [ADDR_SIZE-1:0] addr_2,
  output logic                 en_2,
  output logic                 first,
  output logic                 last,
  output logic                 final_beat
);

  localparam int K     = KERNEL_SIZE;
  localparam int KK    = K * K;
  localparam int BEATS = beats_per_window(K);
  localparam int RW    = $clog2(IMG_H - K + 2);
  localparam int CW    = $clog2(IMG_W - K + 2);
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [RW-1:0] WR_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0] WC_LAST = CW'(IMG_W - K);
  localparam logic [BW-1:0] B_LAST  = BW'(BEATS - 1);

  logic [RW-1:0] wr;
  logic [CW-1:0] wc;
  logic [BW-1:0] b;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      wc <= '0;
      b  <= '0;
    end else if (advance) begin
      if (b == B_LAST) begin
        b <= '0;
        if (wc == WC_LAST) begin
          wc <= '0;
          wr <= (wr == WR_LAST) ? '0 : wr + RW'(1);
        end else begin
          wc <= wc + CW'(1);
        end
      end else begin
        b <= b + BW'(1);
      end
    end
  end

  int e1;
  int e2;
  int a1;
  int a2;

  // The odd tail element has no pixel, so port 2 is gated off there.
  always_comb begin
    e1     = 2 * int'(b);
    e2     = e1 + 1;
    a1     = (int'(wr) + e1 / K) * IMG_W + int'(wc) + e1 % K;
    a2     = (int'(wr) + e2 / K) * IMG_W + int'(wc) + e2 % K;
    en_2   = (e2 < KK);
    addr_1 = ADDR_SIZE'(a1);
    addr_2 = en_2 ? ADDR_SIZE'(a2) : '0;
  end

  assign first      = (b == '0);
  assign last       = (b == B_LAST);
  assign final_beat = last && (wc == WC_LAST) && (wr == WR_LAST);

endmodule

// File: rtl/conv_bank_sequencer.sv
// Loads a raster image into a dual-read bank, then streams every
// KxK window as pixel pairs tagged with window first/last flags.
module conv_bank_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_SIZE-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en_1,
  output logic                  mem_rd_en_2,
  output logic [ADDR_SIZE-1:0]  mem_rd_addr_1,
  output logic [ADDR_SIZE-1:0]  mem_rd_addr_2,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_1,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_2,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  if (IMG_W * IMG_H > 2 ** ADDR_SIZE) begin : g_bad_addr
    $error("image does not fit in bank address space");
  end
  if (KERNEL_SIZE > IMG_W || KERNEL_SIZE > IMG_H) begin : g_bad_k
    $error("kernel larger than image");
  end

  localparam logic [ADDR_SIZE-1:0] PIX_LAST =
    ADDR_SIZE'(IMG_W * IMG_H - 1);

  seq_state_t state;
  seq_state_t next;

  logic [ADDR_SIZE-1:0] pix;
  logic                 hs;
  logic                 issue;
  logic [ADDR_SIZE-1:0] a1;
  logic [ADDR_SIZE-1:0] a2;
  logic                 en2;
  logic                 first;
  logic                 last;
  logic                 final_beat;

  assign hs    = (state == LOAD) && in_valid;
  assign issue = (state == READ);

  conv_window_addr_gen #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .KERNEL_SIZE(KERNEL_SIZE),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .advance   (issue),
    .addr_1    (a1),
    .addr_2    (a2),
    .en_2      (en2),
    .first     (first),
    .last      (last),
    .final_beat(final_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = LOAD;
      LOAD:    if (hs && pix == PIX_LAST) next = READ;
      READ:    if (final_beat) next = DRAIN;
      DRAIN:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Flags ride one cycle behind issue to line up with bank latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (hs) pix <= (pix == PIX_LAST) ? '0 : pix + ADDR_SIZE'(1);
      out_valid <= issue;
      out_first <= issue && first;
      out_last  <= issue && last;
    end
  end

  assign in_ready      = (state == LOAD);
  assign mem_wr_en     = hs;
  assign mem_wr_addr   = hs ? pix : '0;
  assign mem_wr_data   = hs ? in_data : '0;
  assign mem_rd_en_1   = issue;
  assign mem_rd_en_2   = issue && en2;
  assign mem_rd_addr_1 = issue ? a1 : '0;
  assign mem_rd_addr_2 = issue ? a2 : '0;
  assign out_data_1    = out_valid ? mem_rd_data_1 : '0;
  assign out_data_2    = out_valid ? mem_rd_data_2 : '0;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: doc/conv_bank_sequencer.md
Name: conv_bank_sequencer

Overview:
Controller for one dual-read convolution memory bank. It loads a raster-ordered image into the bank through a valid/ready stream. It then walks every valid KERNEL_SIZE x KERNEL_SIZE window and uses both read ports to issue two kernel-element addresses per cycle. It forwards the returned pixel pairs, tagged with window-first and window-last flags, to the downstream MAC.

Parameters:
IMG_W, 4, image width in pixels
IMG_H, 4, image height in pixels
KERNEL_SIZE, 3, square kernel edge; must be <= min(IMG_W, IMG_H)
DATA_WIDTH, 8, pixel width
ADDR_SIZE, 4, bank address width; IMG_W*IMG_H <= 2**ADDR_SIZE (elaboration assertion)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin load+scan; sampled only in IDLE
in_valid  in  1  load pixel valid
in_data  in  DATA_WIDTH  load pixel, raster order
in_ready  out  1  high only in LOAD
mem_wr_en  out  1  to bank wr_en
mem_wr_addr  out  ADDR_SIZE  to bank wr_addr
mem_wr_data  out  DATA_WIDTH  to bank data_in
mem_rd_en_1, mem_rd_en_2  out  1 each  to bank read enables
mem_rd_addr_1, mem_rd_addr_2  out  ADDR_SIZE each  to bank read addresses
mem_rd_data_1, mem_rd_data_2  in  DATA_WIDTH each  bank data_out (1-cycle registered latency)
out_valid  out  1  pixel pair valid
out_data_1, out_data_2  out  DATA_WIDTH each  kernel elements 2b and 2b+1
out_first  out  1  first beat of a window
out_last  out  1  last beat of a window
busy  out  1  high in any state except IDLE
done  out  1  single-cycle pulse at end of scan

Behaviour:
- Reset: state=IDLE. All outputs are 0, all counters are 0. Bank contents are untouched. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE -> LOAD (start=1) -> READ (IMG_W*IMG_H pixels accepted) -> DRAIN (last read issued) -> DONE (1 cycle) -> IDLE.
- IDLE: start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem_wr_en=1, mem_wr_data=in_data, mem_wr_addr=pixel count. These are combinational from the handshake.
  - Pixel count increments on each handshake. Gaps in in_valid stall the count.
  - The handshake on pixel IMG_W*IMG_H-1 moves the FSM to READ.
- READ:
  - Window origin (wr, wc) scans row-major over 0..IMG_H-K and 0..IMG_W-K.
  - Kernel elements e=0..K*K-1 are row-major, with (ki, kj) = (e/K, e%K).
  - Beat b covers elements 2b and 2b+1. There are BEATS = ceil(K*K/2) beats per window.
  - Each element's address is (wr+ki)*IMG_W + (wc+kj), truncated to ADDR_SIZE.
  - mem_rd_en_1=1 every READ cycle.
  - mem_rd_en_2=1 unless 2b+1 >= K*K. On that odd tail the bank returns 0 on port 2.
  - One beat is issued per cycle with no bubbles between windows.
  - Issuing the last beat of the last window moves the FSM to DRAIN.
- Output pipeline:
  - out_valid, out_first (b==0) and out_last (b==BEATS-1) are the issue-cycle flags registered by one cycle.
  - out_data_1/2 = mem_rd_data_1/2 directly, aligned with the registered out_valid.
  - All out_* flags are 0 when out_valid=0.
  - There is no output backpressure; the downstream must accept every beat.
- DRAIN: no reads; the final out_valid beat appears this cycle.
- DONE: done=1 for one cycle, then IDLE.
- Counters wrap to 0 at their terminal values. There is no off-image address generation.
- Window count is (IMG_H-K+1)*(IMG_W-K+1). Total READ cycles = windows*BEATS.

Decomposition:
- Shared package conv_pkg holds:
  - state enum seq_state_t {IDLE, LOAD, READ, DRAIN, DONE}
  - function beats_per_window(K) = (K*K+1)/2
  - function num_windows(W, H, K)
- One sub-module is natural: conv_window_addr_gen. It holds the origin and kernel cursors and produces the two addresses, the port-2 enable, and the first/last/final flags.
- The FSM, load counter and output register stay in the top.

Test Plan:
- Basic 4x4/K=3 scan: load 0..15 with in_valid held, then run the scan.
  - 16 writes go to addresses 0..15.
  - Window (0,0) beats are (0,1), (2,4), (5,6), (8,9), (10,0); out_first on beat 0, out_last on beat 4.
  - Window (0,1) starts (1,2); windows run in order (0,0), (0,1), (1,0), (1,1).
  - Total 20 valid beats, then done is high exactly one cycle after the last beat.
- Load gaps: toggle in_valid every other cycle.
  - Writes occur only on handshakes.
  - READ starts only after the 16th accept.
  - Output is identical to the basic scan.
- Odd-tail port gating: check mem_rd_en_2=0 on every 5th READ cycle (K=3) and out_data_2=0 on the matching beat.
- start while busy: pulse start during LOAD and READ.
  - No restart occurs and counters are unaffected.
  - Exactly one done pulse.
- Reset mid-READ: assert rst at beat 7.
  - Next cycle: IDLE, all outputs 0, no done.
  - A fresh start with reload reproduces the full basic-scan sequence.
- Parameter sweep IMG_W=IMG_H=K=2:
  - One window with beats (0,1), (2,3); out_first and out_last land on beats 0 and 1 respectively.
  - mem_rd_en_2 is always 1.
